// File: rtl/decode_pkg.sv
// Shared encodings for the D-stage decoder: ALU commands, DP cmd field values,
// major opcodes, extend/register-select codes, the MUL sequencer states and
// the control bundle that travels from decode into the E register.
package decode_pkg;

    localparam int unsigned ALU_CMD_W = 3;
    localparam int unsigned SEQ_CNT_W = 4;

    // ALU commands (zero-extended to ALUC_W at the stage boundary)
    localparam logic [ALU_CMD_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_CMD_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_CMD_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_CMD_W-1:0] ALU_ORR = 3'b011;
    localparam logic [ALU_CMD_W-1:0] ALU_EOR = 3'b100;
    localparam logic [ALU_CMD_W-1:0] ALU_MOV = 3'b101;

    // Data-processing cmd field, InstrD[24:21]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // Major opcode, InstrD[27:26]
    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    // Register-file read selects and extend-unit selects
    localparam logic [1:0] REGSRC_DP  = 2'b00;
    localparam logic [1:0] REGSRC_BR  = 2'b01;
    localparam logic [1:0] REGSRC_STR = 2'b10;
    localparam logic [1:0] IMMSRC_DP  = 2'b00;
    localparam logic [1:0] IMMSRC_MEM = 2'b01;
    localparam logic [1:0] IMMSRC_BR  = 2'b10;

    typedef enum logic [0:0] {
        SEQ_IDLE  = 1'b0,
        SEQ_MWAIT = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic                 pcs;
        logic                 reg_w;
        logic                 mem_w;
        logic                 mem_to_reg;
        logic                 alu_src;
        logic                 branch;
        logic                 mul;
        logic [1:0]           flag_w;
        logic [ALU_CMD_W-1:0] alu_ctrl;
        logic [3:0]           cond;
        logic                 illegal;
    } ctrl_t;

endpackage

// File: rtl/decode_comb.sv
// Combinational main + ALU decoder.
// Ports: instr (32-bit D-stage instruction) in; reg_src, imm_src (D-stage
// selects) and ctrl (execute-side control bundle incl. illegal flag) out.
module decode_comb
    import decode_pkg::*;
#(
    parameter bit MUL_EN = 1'b1
) (
    input  logic [31:0] instr,
    output logic [1:0]  reg_src,
    output logic [1:0]  imm_src,
    output ctrl_t       ctrl
);

    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       is_mul;
    logic       unused_bits;

    assign op     = instr[27:26];
    assign funct  = instr[25:20];
    assign cmd    = funct[4:1];
    assign is_mul = (op == OP_DP) && (instr[25:22] == 4'b0000) && (instr[7:4] == 4'b1001);

    // Operand/shift fields are consumed by the datapath, not the decoder
    assign unused_bits = ^{instr[11:8], instr[3:0]};

    // Main decode, then PCS, then the illegal override
    always_comb begin
        logic [3:0] rd;
        logic       s_bit;

        reg_src   = REGSRC_DP;
        imm_src   = IMMSRC_DP;
        ctrl      = '0;
        ctrl.cond = instr[31:28];
        rd        = instr[15:12];
        s_bit     = funct[0];

        case (op)
            OP_DP: begin
                if (is_mul) begin
                    if (MUL_EN) begin
                        ctrl.reg_w  = 1'b1;
                        ctrl.mul    = 1'b1;
                        ctrl.flag_w = {s_bit, 1'b0};
                        rd          = instr[19:16];
                    end else begin
                        ctrl.illegal = 1'b1;
                    end
                end else begin
                    ctrl.alu_src = funct[5];
                    ctrl.reg_w   = 1'b1;
                    case (cmd)
                        CMD_ADD: ctrl.alu_ctrl = ALU_ADD;
                        CMD_SUB: ctrl.alu_ctrl = ALU_SUB;
                        CMD_AND: ctrl.alu_ctrl = ALU_AND;
                        CMD_ORR: ctrl.alu_ctrl = ALU_ORR;
                        CMD_EOR: ctrl.alu_ctrl = ALU_EOR;
                        CMD_MOV: ctrl.alu_ctrl = ALU_MOV;
                        CMD_CMP: begin
                            ctrl.alu_ctrl = ALU_SUB;
                            ctrl.reg_w    = 1'b0;
                            s_bit         = 1'b1;
                        end
                        default: ctrl.illegal = 1'b1;
                    endcase
                    ctrl.flag_w = {s_bit,
                                   s_bit & ((cmd == CMD_ADD) | (cmd == CMD_SUB) | (cmd == CMD_CMP))};
                end
            end
            OP_MEM: begin
                imm_src       = IMMSRC_MEM;
                ctrl.alu_src  = 1'b1;
                ctrl.alu_ctrl = ALU_ADD;
                if (funct[0]) begin
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_w      = 1'b1;
                end else begin
                    reg_src    = REGSRC_STR;
                    ctrl.mem_w = 1'b1;
                end
            end
            OP_BR: begin
                reg_src       = REGSRC_BR;
                imm_src       = IMMSRC_BR;
                ctrl.alu_src  = 1'b1;
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = ALU_ADD;
            end
            default: ctrl.illegal = 1'b1;
        endcase

        ctrl.pcs = ((rd == 4'hF) & ctrl.reg_w) | ctrl.branch;

        // An undefined encoding carries only its condition and the flag
        if (ctrl.illegal) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
            ctrl.cond    = instr[31:28];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Pipelined decode stage: combinational D-stage selects, the D/E control
// register with flush/hold/busy qualification, and the multi-cycle MUL
// sequencer that stalls F/D while a MUL occupies execute.
// Ports: clk, reset (async, active-high); InstrD/ValidD in; HoldE/FlushE in;
// RegSrcD/ImmSrcD comb out; BusyD stall out; registered E-side controls out.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned ALUC_W  = 3,
    parameter bit          MUL_EN  = 1'b1,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       InstrD,
    input  logic              ValidD,
    input  logic              HoldE,
    input  logic              FlushE,
    output logic [1:0]        RegSrcD,
    output logic [1:0]        ImmSrcD,
    output logic              BusyD,
    output logic              ValidE,
    output logic              PCSE,
    output logic              RegWE,
    output logic              MemWE,
    output logic              MemtoRegE,
    output logic              ALUSrcE,
    output logic              BranchE,
    output logic              MulE,
    output logic [1:0]        FlagWE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic [3:0]        CondE,
    output logic              IllegalE
);

    localparam logic [SEQ_CNT_W-1:0] MUL_WAIT = SEQ_CNT_W'(MUL_LAT - 1);

    ctrl_t                dec_ctrl;
    ctrl_t                e_q;
    ctrl_t                e_d;
    logic                 valid_q;
    logic                 valid_d;
    seq_state_t           state_q;
    seq_state_t           state_d;
    logic [SEQ_CNT_W-1:0] cnt_q;
    logic [SEQ_CNT_W-1:0] cnt_d;
    logic                 busy_q;
    logic                 mul_issue;

    decode_comb #(
        .MUL_EN (MUL_EN)
    ) u_decode_comb (
        .instr   (InstrD),
        .reg_src (RegSrcD),
        .imm_src (ImmSrcD),
        .ctrl    (dec_ctrl)
    );

    // A MUL is issued only when it actually lands in the E register
    assign mul_issue = ~FlushE & ~HoldE & ~busy_q & ValidD & dec_ctrl.mul;

    // E register next value: flush > hold > busy bubble > load
    always_comb begin
        e_d     = e_q;
        valid_d = valid_q;
        if (FlushE) begin
            e_d     = '0;
            valid_d = 1'b0;
        end else if (HoldE) begin
            e_d     = e_q;
            valid_d = valid_q;
        end else if (busy_q) begin
            e_d     = '0;
            valid_d = 1'b0;
        end else begin
            e_d     = ValidD ? dec_ctrl : '0;
            valid_d = ValidD;
        end
    end

    // MUL sequencer next state; cnt counts remaining busy cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SEQ_IDLE: begin
                if (mul_issue && (MUL_LAT > 1)) begin
                    state_d = SEQ_MWAIT;
                    cnt_d   = MUL_WAIT;
                end
            end
            SEQ_MWAIT: begin
                if (FlushE) begin
                    state_d = SEQ_IDLE;
                    cnt_d   = '0;
                end else if (!HoldE) begin
                    if (cnt_q == SEQ_CNT_W'(1)) begin
                        state_d = SEQ_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - SEQ_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = SEQ_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q     <= '0;
            valid_q <= 1'b0;
            state_q <= SEQ_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            e_q     <= e_d;
            valid_q <= valid_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == SEQ_MWAIT);
        end
    end

    assign BusyD       = busy_q;
    assign ValidE      = valid_q;
    assign PCSE        = e_q.pcs;
    assign RegWE       = e_q.reg_w;
    assign MemWE       = e_q.mem_w;
    assign MemtoRegE   = e_q.mem_to_reg;
    assign ALUSrcE     = e_q.alu_src;
    assign BranchE     = e_q.branch;
    assign MulE        = e_q.mul;
    assign FlagWE      = e_q.flag_w;
    assign ALUControlE = ALUC_W'(e_q.alu_ctrl);
    assign CondE       = e_q.cond;
    assign IllegalE    = e_q.illegal;

endmodule
